// File: rtl/adder32_slice_seq_if.sv
// rtl/adder32_slice_seq_if.sv - operand/result valid-ready bundle for adder32_slice_seq
interface adder32_slice_seq_if #(
    parameter int WIDTH = 32
) ();
    localparam int NSLICE = WIDTH / 4;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [NSLICE-1:0] approx_mask;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_sum;
    logic              out_cout;

    modport master (
        output in_valid, in_a, in_b, approx_mask, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, approx_mask, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/adder32_slice_seq.sv
// rtl/adder32_slice_seq.sv - sequenced nibble-slice adder, optional ADDER_ERR_STAT_EN error counter
module adder32_slice_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    adder32_slice_seq_if.slave    bus,
    output logic                  busy
`ifdef ADDER_ERR_STAT_EN
    ,
    output logic [CNTW-1:0]       err_count
`endif
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if ((WIDTH % 4) != 0 || WIDTH < 4 || CNTW < 1) begin : g_bad_param
        $error("adder32_slice_seq: WIDTH must be a positive multiple of 4 and CNTW >= 1");
    end

    logic [1:0]        state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  sum_r;
    logic [NSLICE-1:0] mask_r;
    logic              carry_r;
    logic              cout_r;
    logic [IDXW-1:0]   idx;

    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic              mask_bit;
    logic              cin;
    logic [4:0]        slice_res;
    logic              last;

    // Constant-index mux keeps the nibble select free of computed bit offsets.
    always_comb begin
        a_nib    = 4'd0;
        b_nib    = 4'd0;
        mask_bit = 1'b0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDXW'(i)) begin
                a_nib    = a_r[4*i +: 4];
                b_nib    = b_r[4*i +: 4];
                mask_bit = mask_r[i];
            end
        end
        cin       = (idx == '0 || mask_bit) ? 1'b0 : carry_r;
        slice_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'd0, cin};
        last      = (idx == IDXW'(NSLICE - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            mask_r  <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r     <= bus.in_a;
                        b_r     <= bus.in_b;
                        mask_r  <= bus.approx_mask;
                        sum_r   <= '0;
                        carry_r <= 1'b0;
                        cout_r  <= 1'b0;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (idx == IDXW'(i)) begin
                            sum_r[4*i +: 4] <= slice_res[3:0];
                        end
                    end
                    carry_r <= slice_res[4];
                    if (last) begin
                        cout_r <= slice_res[4];
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        idx   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = sum_r;
    assign bus.out_cout  = cout_r;
    assign busy          = (state == RUN);

`ifdef ADDER_ERR_STAT_EN
    logic       sh_carry;
    logic       sh_cin;
    logic       mism;
    logic [4:0] sh_res;

    assign sh_cin = (idx == '0) ? 1'b0 : sh_carry;
    assign sh_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'd0, sh_cin};

    // Intermediate carries may legitimately differ; only sum nibbles and the final carry count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_carry  <= 1'b0;
            mism      <= 1'b0;
            err_count <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            sh_carry <= 1'b0;
            mism     <= 1'b0;
        end else if (state == RUN) begin
            sh_carry <= sh_res[4];
            if (last) begin
                if ((mism || sh_res != slice_res) && err_count != {CNTW{1'b1}}) begin
                    err_count <= err_count + 1'b1;
                end
            end else if (sh_res[3:0] != slice_res[3:0]) begin
                mism <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_adder32_slice_seq.sv
// tb/tb_adder32_slice_seq.sv - randomized self-checking bench for adder32_slice_seq
module tb_adder32_slice_seq;
    localparam int WIDTH  = 32;
    localparam int NSLICE = WIDTH / 4;
    localparam int CNTW   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
`ifdef ADDER_ERR_STAT_EN
    logic [CNTW-1:0] err_count;
`endif

    adder32_slice_seq_if #(.WIDTH(WIDTH)) bus ();

    adder32_slice_seq #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy)
`ifdef ADDER_ERR_STAT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_err      = 0;

    // Approximate result: each run of slices between cut points is an independent exact add.
    function automatic logic [WIDTH:0] model_approx(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                                    logic [NSLICE-1:0] m);
        logic [WIDTH-1:0] s;
        logic             c;
        int               start;
        int               w;
        logic [63:0]      segmask;
        logic [63:0]      t;
        s = '0;
        c = 1'b0;
        start = 0;
        for (int i = 1; i <= NSLICE; i++) begin
            if (i == NSLICE || m[i]) begin
                w       = 4 * (i - start);
                segmask = (64'd1 << w) - 64'd1;
                t       = ((64'(a) >> (4 * start)) & segmask) + ((64'(b) >> (4 * start)) & segmask);
                s       = s | WIDTH'((t & segmask) << (4 * start));
                c       = t[w];
                start   = i;
            end
        end
        return {c, s};
    endfunction

    function automatic logic [WIDTH:0] model_exact(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic note_err(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [NSLICE-1:0] m);
        if (model_approx(a, b, m) != model_exact(a, b) && exp_err < (1 << CNTW) - 1)
            exp_err++;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [NSLICE-1:0] m,
                          output logic [WIDTH-1:0] s, output logic c, output int lat);
        bus.in_valid    = 1'b1;
        bus.in_a        = a;
        bus.in_b        = b;
        bus.approx_mask = m;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        note_err(a, b, m);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        s = bus.out_sum;
        c = bus.out_cout;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (bus.out_sum !== '0 || bus.out_cout !== 1'b0) begin tests_failed++; $display("FAIL reset_out got %h/%b want 0/0", bus.out_sum, bus.out_cout); end
`ifdef ADDER_ERR_STAT_EN
        tests_run++; if (err_count !== '0) begin tests_failed++; $display("FAIL reset_err_count got %0d want 0", err_count); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed(string name, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                 logic [NSLICE-1:0] m, logic [WIDTH-1:0] want_s, logic want_c);
        logic [WIDTH-1:0] s;
        logic             c;
        int               lat;
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL %s_in_ready got %b want 1", name, bus.in_ready); end
        run_op(a, b, m, s, c, lat);
        tests_run++; if (lat !== NSLICE) begin tests_failed++; $display("FAIL %s_latency got %0d want %0d", name, lat, NSLICE); end
        tests_run++; if (s !== want_s) begin tests_failed++; $display("FAIL %s_sum got %h want %h", name, s, want_s); end
        tests_run++; if (c !== want_c) begin tests_failed++; $display("FAIL %s_cout got %b want %b", name, c, want_c); end
        tests_run++; if ({c, s} !== model_approx(a, b, m)) begin tests_failed++; $display("FAIL %s_model got %h want %h", name, {c, s}, model_approx(a, b, m)); end
`ifdef ADDER_ERR_STAT_EN
        tests_run++; if (err_count !== CNTW'(exp_err)) begin tests_failed++; $display("FAIL %s_err_count got %0d want %0d", name, err_count, exp_err); end
`endif
        release_result();
        tests_run++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL %s_release got valid=%b ready=%b want 0/1", name, bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_random(int n);
        logic [WIDTH-1:0]  a, b, s;
        logic [NSLICE-1:0] m;
        logic              c;
        int                lat;
        for (int k = 0; k < n; k++) begin
            a = $urandom;
            b = $urandom;
            m = NSLICE'($urandom);
            if (k % 4 == 0) m = '0;
            run_op(a, b, m, s, c, lat);
            tests_run++; if ({c, s} !== model_approx(a, b, m) || lat !== NSLICE) begin
                tests_failed++;
                $display("FAIL random_%0d got %h lat %0d want %h lat %0d", k, {c, s}, lat, model_approx(a, b, m), NSLICE);
            end
            if (m == '0) begin
                tests_run++; if ({c, s} !== model_exact(a, b)) begin tests_failed++; $display("FAIL random_exact_%0d got %h want %h", k, {c, s}, model_exact(a, b)); end
            end
`ifdef ADDER_ERR_STAT_EN
            tests_run++; if (err_count !== CNTW'(exp_err)) begin tests_failed++; $display("FAIL random_err_%0d got %0d want %0d", k, err_count, exp_err); end
`endif
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] s0;
        logic             c0;
        int               lat;
        run_op(32'hCAFE_F00D, 32'h3501_0FF3, 8'h10, s0, c0, lat);
        tests_run++; if ({c0, s0} !== model_approx(32'hCAFE_F00D, 32'h3501_0FF3, 8'h10)) begin tests_failed++; $display("FAIL bp_result got %h want %h", {c0, s0}, model_approx(32'hCAFE_F00D, 32'h3501_0FF3, 8'h10)); end
        for (int k = 0; k < 5; k++) begin
            bus.in_valid    = 1'b1;
            bus.in_a        = $urandom;
            bus.in_b        = $urandom;
            bus.approx_mask = NSLICE'($urandom);
            @(posedge clk); #1;
            tests_run++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL bp_hold_ctl_%0d got valid=%b ready=%b busy=%b want 1/0/0", k, bus.out_valid, bus.in_ready, busy); end
            tests_run++; if (bus.out_sum !== s0 || bus.out_cout !== c0) begin tests_failed++; $display("FAIL bp_hold_data_%0d got %h/%b want %h/%b", k, bus.out_sum, bus.out_cout, s0, c0); end
        end
        bus.in_valid = 1'b0;
        release_result();
        tests_run++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_operand_change();
        logic [WIDTH-1:0]  a0, b0;
        logic [NSLICE-1:0] m0;
        int                lat;
        a0 = $urandom; b0 = $urandom; m0 = NSLICE'($urandom);
        bus.in_valid = 1'b1; bus.in_a = a0; bus.in_b = b0; bus.approx_mask = m0;
        @(posedge clk); #1;
        note_err(a0, b0, m0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            bus.in_valid    = 1'($urandom);
            bus.in_a        = $urandom;
            bus.in_b        = $urandom;
            bus.approx_mask = NSLICE'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        tests_run++; if (lat !== NSLICE) begin tests_failed++; $display("FAIL chg_latency got %0d want %0d", lat, NSLICE); end
        tests_run++; if ({bus.out_cout, bus.out_sum} !== model_approx(a0, b0, m0)) begin tests_failed++; $display("FAIL chg_result got %h want %h", {bus.out_cout, bus.out_sum}, model_approx(a0, b0, m0)); end
        release_result();
    endtask

    task automatic test_reset_mid_run();
        bus.in_valid = 1'b1; bus.in_a = 32'hFFFF_FFFF; bus.in_b = 32'h0000_0001; bus.approx_mask = '0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL midrst_busy got %b want 1", busy); end
        rst = 1'b1;
        #1;
        exp_err = 0;
        tests_run++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_ctl got ready=%b valid=%b busy=%b want 1/0/0", bus.in_ready, bus.out_valid, busy); end
        tests_run++; if (bus.out_sum !== '0 || bus.out_cout !== 1'b0) begin tests_failed++; $display("FAIL midrst_out got %h/%b want 0/0", bus.out_sum, bus.out_cout); end
`ifdef ADDER_ERR_STAT_EN
        tests_run++; if (err_count !== '0) begin tests_failed++; $display("FAIL midrst_err_count got %0d want 0", err_count); end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_directed("post_rst", 32'h0000_FFFF, 32'h0000_0001, 8'h00, 32'h0001_0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0]  a, b, s;
        logic [NSLICE-1:0] m;
        logic              c;
        int                lat;
        time               t_prev, t_now;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            a = $urandom; b = $urandom; m = NSLICE'($urandom);
            t_now = $time;
            run_op(a, b, m, s, c, lat);
            tests_run++; if ({c, s} !== model_approx(a, b, m)) begin tests_failed++; $display("FAIL b2b_result_%0d got %h want %h", k, {c, s}, model_approx(a, b, m)); end
            if (k > 0) begin
                tests_run++; if ((t_now - t_prev) !== 100) begin tests_failed++; $display("FAIL b2b_period_%0d got %0t want 100", k, t_now - t_prev); end
            end
            t_prev = t_now;
            release_result();
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_a        = '0;
        bus.in_b        = '0;
        bus.approx_mask = '0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_directed("exact_carry", 32'hFFFF_FFFF, 32'h0000_0001, 8'h00, 32'h0000_0000, 1'b1);
        test_directed("cut_slice1",  32'hFFFF_FFFF, 32'h0000_0001, 8'h02, 32'hFFFF_FFF0, 1'b0);
        test_directed("all_cut",     32'h1234_5678, 32'h1111_1111, 8'hFF, 32'h2345_6789, 1'b0);
        test_directed("mask0_dc",    32'hFFFF_FFFF, 32'h0000_0001, 8'h01, 32'h0000_0000, 1'b1);
        test_random(20);
        test_backpressure();
        test_operand_change();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/adder32_slice_seq.md
Name: adder32_slice_seq

Overview:
- Multi-cycle 32-bit adder controller. It time-shares one 8-input / 5-output nibble partition slice (a[3:0], b[3:0] in; sum[3:0], carry out) across all nibbles of the operands.
- Per-nibble exact/approximate selection comes from a configuration mask latched at operation start.
- Sits between an operand producer and a result consumer. Uses valid/ready on both sides.
- Lets one partition netlist, exact or carry-cut approximate, be evaluated across the full adder width under a sequencer.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of 4; elaboration error otherwise.
- NSLICE, WIDTH/4, derived. Number of nibble slices and number of RUN cycles.
- CNTW, 16, width of the optional error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mask valid.
- in_ready  output  1  block can accept an operation.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- approx_mask  input  NSLICE  bit i=1 makes slice i approximate (carry-in cut).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  sum.
- out_cout  output  1  carry out of the top slice.
- busy  output  1  high in RUN.
- err_count  output  CNTW  present only with ADDER_ERR_STAT_EN.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous, active-high.
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out_sum=0, out_cout=0, slice index=0, carry register=0, err_count=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready at an edge: latch in_a, in_b, approx_mask; clear the sum register and carry; idx=0; go to RUN.
- RUN: in_ready=0, busy=1. Each cycle evaluates slice idx:
  - cin = 0 if idx==0 or mask[idx]==1; else cin = carry register.
  - {c,s} = a[4idx+3:4idx] + b[4idx+3:4idx] + cin, a 5-bit result.
  - s is written to sum[4idx+3:4idx]; carry register <= c. An approximate slice still propagates its own carry out.
  - idx increments. After idx==NSLICE-1 is processed: out_cout <= c, go to DONE.
- DONE: out_valid=1, out_sum/out_cout stable.
  - On out_valid&&out_ready: go to IDLE; out_valid drops next cycle.
  - While out_ready=0, hold indefinitely with outputs unchanged.
- Latency: accept edge T gives out_valid high after edge T+NSLICE (8 cycles for WIDTH=32). Throughput is one operation per NSLICE+2 cycles minimum.
- No accept in RUN or DONE; in_valid is ignored there. Operand or mask changes after acceptance have no effect.
- mask bit 0 is a don't-care, since slice 0 always has cin=0.
- All-zero mask gives the exact WIDTH-bit sum modulo 2^WIDTH, with the true carry out.
- rst asserted mid-RUN or in DONE aborts immediately to reset values. No partial result is presented.
- idx wraps only via return to IDLE. It never exceeds NSLICE-1.

Optional Feature:
- ADDER_ERR_STAT_EN defined:
  - An exact shadow carry chain runs in parallel during RUN.
  - At the DONE entry edge, if {out_cout,out_sum} differs from the exact {cout,sum}, err_count increments.
  - err_count saturates at 2^CNTW-1 and is cleared only by rst.
  - The err_count port exists only when the macro is defined.
- Undefined: no shadow chain, no counter, no err_count port. Datapath timing and FSM are identical in both builds.

Test Plan:
- A=0xFFFFFFFF, B=0x00000001, mask=0x00 -> out_sum=0x00000000, out_cout=1, out_valid rises exactly 8 cycles after accept.
- Same operands, mask=0x02 (slice 1 cut) -> out_sum=0xFFFFFFF0, out_cout=0; with ADDER_ERR_STAT_EN, err_count 0->1.
- A=0x12345678, B=0x11111111, mask=0xFF -> out_sum=0x23456789, out_cout=0 (no carries generated), err_count unchanged.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_sum, out_cout stable; in_ready=0; in_valid pulses ignored. Release -> IDLE, in_ready=1 next cycle.
- Change in_a/approx_mask every cycle during RUN -> result equals the values latched at accept.
- Assert rst at RUN idx=3 -> in_ready=1, out_valid=0, out_sum=0, err_count=0 immediately. A following operation 0x0000FFFF+0x00000001 with mask 0 -> out_sum=0x00010000, out_cout=0.
